// File: rtl/param_coeff_loader_pkg.sv
// Shared types and constants for the FIR coefficient loader.
package coeff_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, CLEAR} state_t;

    localparam int DEFAULT_NUM_COEFF = 4;
    localparam int TIMER_W           = 16;

endpackage

// File: rtl/param_coeff_loader_if.sv
// Handshake bundle between the slave register block, the loader and the FIR controller.
interface param_coeff_loader_if #(
    parameter int IDX_W = 2
);
    logic             new_coefficient_set;
    logic             modwait;
    logic             abort;
    logic             load_coeff;
    logic [IDX_W-1:0] coefficient_num;
    logic             clear_new_coeff;
    logic             busy;
    logic             load_err;

    modport master (
        input  new_coefficient_set, modwait, abort,
        output load_coeff, coefficient_num, clear_new_coeff, busy, load_err
    );

    modport slave (
        output new_coefficient_set, modwait, abort,
        input  load_coeff, coefficient_num, clear_new_coeff, busy, load_err
    );
endinterface

// File: rtl/param_coeff_loader_wait_timer.sv
// Clearable, enabled up-counter; expire flags the enabled cycle that completes TIMEOUT counts.
module wait_timer
    import coeff_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TIMER_W'(1);
        end
    end

    // Matching TIMEOUT-1 while enabled means this stalled cycle is the TIMEOUT-th one.
    assign expire = en && (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/param_coeff_loader.sv
// Sequences NUM_COEFF coefficient loads into the FIR register file, with abort and stall timeout.
module param_coeff_loader
    import coeff_pkg::*;
#(
    parameter int NUM_COEFF = DEFAULT_NUM_COEFF,
    parameter int IDX_W     = $clog2(NUM_COEFF),
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 n_reset,
    param_coeff_loader_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFF - 1);

    state_t           state;
    logic [IDX_W-1:0] index;
    logic             err_q;
    logic             tmr_clr;
    logic             tmr_en;
    logic             tmr_expire;

    assign tmr_clr = (state == LOAD);
    assign tmr_en  = (state == WAIT) && bus.modwait;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expire  (tmr_expire)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            index <= '0;
            err_q <= 1'b0;
        end else if (bus.abort) begin
            // Abort overrides everything; the pending-set level is left for the slave to keep.
            state <= IDLE;
            index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.new_coefficient_set) begin
                        state <= LOAD;
                        index <= '0;
                        err_q <= 1'b0;
                    end
                end
                LOAD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!bus.modwait) begin
                        if (index == LAST_IDX) begin
                            state <= CLEAR;
                        end else begin
                            index <= index + IDX_W'(1);
                            state <= LOAD;
                        end
                    end else if (tmr_expire) begin
                        err_q <= 1'b1;
                        state <= IDLE;
                        index <= '0;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                    index <= '0;
                end
                default: begin
                    state <= IDLE;
                    index <= '0;
                end
            endcase
        end
    end

    assign bus.load_coeff      = (state == LOAD);
    assign bus.clear_new_coeff = (state == CLEAR);
    assign bus.busy            = (state != IDLE);
    assign bus.load_err        = err_q;
    assign bus.coefficient_num = ((state == LOAD) || (state == WAIT)) ? index : '0;

endmodule

// File: tb/tb_param_coeff_loader.sv
// Bench for param_coeff_loader: three configurations share one stimulus, each checked against a set-level model.
module tb_param_coeff_loader;

    logic clk = 1'b0;
    logic n_reset;
    logic nc, mw, ab;

    always #5 clk = ~clk;

    param_coeff_loader_if #(.IDX_W(2)) a_if ();
    param_coeff_loader_if #(.IDX_W(2)) b_if ();
    param_coeff_loader_if #(.IDX_W(3)) c_if ();

    assign a_if.new_coefficient_set = nc;
    assign a_if.modwait             = mw;
    assign a_if.abort               = ab;
    assign b_if.new_coefficient_set = nc;
    assign b_if.modwait             = mw;
    assign b_if.abort               = ab;
    assign c_if.new_coefficient_set = nc;
    assign c_if.modwait             = mw;
    assign c_if.abort               = ab;

    param_coeff_loader #(.NUM_COEFF(4), .TIMEOUT(255)) dut_a (.clk(clk), .n_reset(n_reset), .bus(a_if.master));
    param_coeff_loader #(.NUM_COEFF(4), .TIMEOUT(10))  dut_b (.clk(clk), .n_reset(n_reset), .bus(b_if.master));
    param_coeff_loader #(.NUM_COEFF(5), .TIMEOUT(255)) dut_c (.clk(clk), .n_reset(n_reset), .bus(c_if.master));

    wire [7:0] act_a = {a_if.load_coeff, 4'(a_if.coefficient_num), a_if.clear_new_coeff, a_if.busy, a_if.load_err};
    wire [7:0] act_b = {b_if.load_coeff, 4'(b_if.coefficient_num), b_if.clear_new_coeff, b_if.busy, b_if.load_err};
    wire [7:0] act_c = {c_if.load_coeff, 4'(c_if.coefficient_num), c_if.clear_new_coeff, c_if.busy, c_if.load_err};

    // Set-level model: a set is a run of slots (strobe, then wait for the datapath), closed by one clear cycle.
    typedef struct packed {
        logic busy;
        logic loading;
        logic closing;
        logic err;
        int   k;
        int   stall;
    } mdl_t;

    mdl_t ma = '0;
    mdl_t mb = '0;
    mdl_t mc = '0;

    function automatic mdl_t mstep(mdl_t m, int ncoef, int tmo, logic nc_i, logic mw_i, logic ab_i);
        mdl_t r = m;
        if (ab_i) begin
            r.busy = 1'b0; r.loading = 1'b0; r.closing = 1'b0; r.k = 0;
        end else if (!m.busy) begin
            if (nc_i) begin
                r.busy = 1'b1; r.loading = 1'b1; r.k = 0; r.err = 1'b0;
            end
        end else if (m.closing) begin
            r.busy = 1'b0; r.closing = 1'b0; r.k = 0;
        end else if (m.loading) begin
            r.loading = 1'b0; r.stall = 0;
        end else if (!mw_i) begin
            if (m.k == ncoef - 1) r.closing = 1'b1;
            else begin
                r.k = m.k + 1; r.loading = 1'b1;
            end
        end else begin
            r.stall = m.stall + 1;
            if (r.stall == tmo) begin
                r.err = 1'b1; r.busy = 1'b0; r.k = 0;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] mexp(mdl_t m);
        return {m.loading, (m.busy && !m.closing) ? m.k[3:0] : 4'd0, m.closing, m.busy, m.err};
    endfunction

    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ma <= '0;
            mb <= '0;
            mc <= '0;
        end else begin
            ma <= mstep(ma, 4, 255, nc, mw, ab);
            mb <= mstep(mb, 4, 10,  nc, mw, ab);
            mc <= mstep(mc, 5, 255, nc, mw, ab);
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (hex)", name, act, exp);
    endtask

    // Every negedge: all three outputs checked against their models, then the caller may drive inputs.
    task automatic tick();
        @(negedge clk);
        chk("cycle_a", int'(act_a), int'(mexp(ma)));
        chk("cycle_b", int'(act_b), int'(mexp(mb)));
        chk("cycle_c", int'(act_c), int'(mexp(mc)));
    endtask

    int a_loads, a_clrs, a_clr_at, a_busy, a_seq;
    int c_loads, c_clr_at, c_busy, c_seq, c_max;
    int b_clrs, clr_early, rem;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nc = 1'b0; mw = 1'b0; ab = 1'b0; n_reset = 1'b0;
        repeat (2) tick();
        chk("reset_outs_a", int'(act_a), 0);
        chk("reset_outs_c", int'(act_c), 0);
        n_reset = 1'b1;
        repeat (2) tick();

        // Basic set, modwait low throughout
        a_loads = 0; a_clr_at = 0; a_busy = 0; a_seq = 0;
        c_loads = 0; c_clr_at = 0; c_busy = 0; c_seq = 0; c_max = 0;
        nc = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (a_if.load_coeff) begin a_loads++; a_seq = (a_seq << 4) | int'(a_if.coefficient_num); end
            if (a_if.clear_new_coeff) a_clr_at = i;
            if (a_if.busy) a_busy++;
            if (c_if.load_coeff) begin c_loads++; c_seq = (c_seq << 4) | int'(c_if.coefficient_num); end
            if (c_if.clear_new_coeff) c_clr_at = i;
            if (c_if.busy) c_busy++;
            if (int'(c_if.coefficient_num) > c_max) c_max = int'(c_if.coefficient_num);
            if (i == 1) nc = 1'b0;
        end
        chk("t1_a_loads", a_loads, 4);
        chk("t1_a_order", a_seq, 'h0123);
        chk("t1_a_clear_cycle", a_clr_at, 9);
        chk("t1_a_busy_cycles", a_busy, 9);
        chk("t1_c_loads", c_loads, 5);
        chk("t1_c_order", c_seq, 'h01234);
        chk("t1_c_clear_cycle", c_clr_at, 11);
        chk("t1_c_busy_cycles", c_busy, 11);
        chk("t1_c_max_index", c_max, 4);

        // Datapath busy for three cycles after every load
        tick();
        a_loads = 0; a_clrs = 0; a_clr_at = 0; c_clr_at = 0; rem = 0;
        nc = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (a_if.load_coeff) a_loads++;
            if (a_if.clear_new_coeff) begin a_clrs++; a_clr_at = i; end
            if (c_if.clear_new_coeff) c_clr_at = i;
            if (i == 1) nc = 1'b0;
            if (a_if.load_coeff || c_if.load_coeff) rem = 5;
            if (rem > 0) rem--;
            mw = (rem > 0);
        end
        mw = 1'b0;
        chk("t2_a_loads", a_loads, 4);
        chk("t2_a_clears", a_clrs, 1);
        chk("t2_a_clear_cycle", a_clr_at, 21);
        chk("t2_c_clear_cycle", c_clr_at, 26);

        // Abort while waiting on index 2, pending level stays high
        tick();
        clr_early = 0;
        nc = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i <= 7 && a_if.clear_new_coeff) clr_early++;
            if (i == 6) begin
                chk("t3_wait_idx2", int'(a_if.coefficient_num), 2);
                ab = 1'b1;
            end
            if (i == 7) begin
                chk("t3_abort_idle", int'(a_if.busy), 0);
                ab = 1'b0;
            end
            if (i == 8) begin
                chk("t3_restart_load", int'(a_if.load_coeff), 1);
                chk("t3_restart_idx", int'(a_if.coefficient_num), 0);
                nc = 1'b0;
            end
        end
        chk("t3_no_clear_on_abort", clr_early, 0);

        // Abort in IDLE blocks a start
        nc = 1'b1; ab = 1'b1;
        repeat (2) tick();
        chk("t3_abort_blocks_start", int'(a_if.busy), 0);
        nc = 1'b0; ab = 1'b0;
        tick();

        // Stalled datapath: dut_b times out after 10 stalled cycles
        b_clrs = 0;
        nc = 1'b1; mw = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i <= 14 && b_if.clear_new_coeff) b_clrs++;
            if (i == 1) nc = 1'b0;
            if (i == 11) begin
                chk("t4_b_err_before", int'(b_if.load_err), 0);
                chk("t4_b_busy_before", int'(b_if.busy), 1);
            end
            if (i == 12) begin
                chk("t4_b_err_set", int'(b_if.load_err), 1);
                chk("t4_b_idle", int'(b_if.busy), 0);
                chk("t4_a_still_wait", int'(a_if.busy), 1);
                chk("t4_a_no_err", int'(a_if.load_err), 0);
            end
            if (i == 13) ab = 1'b1;
            if (i == 14) begin
                ab = 1'b0; mw = 1'b0;
                chk("t4_b_err_sticky", int'(b_if.load_err), 1);
                chk("t4_a_aborted", int'(a_if.busy), 0);
            end
            if (i == 15) nc = 1'b1;
            if (i == 16) begin
                chk("t4_b_err_cleared", int'(b_if.load_err), 0);
                chk("t4_b_new_load", int'(b_if.load_coeff), 1);
                nc = 1'b0;
            end
        end
        chk("t4_b_no_clear", b_clrs, 0);
        repeat (12) tick();

        // Asynchronous reset in the middle of a wait
        nc = 1'b1;
        tick();
        nc = 1'b0; mw = 1'b1;
        tick();
        chk("t5_in_wait", int'(a_if.busy), 1);
        #2;
        n_reset = 1'b0;
        #1;
        chk("t5_async_a", int'(act_a), 0);
        chk("t5_async_b", int'(act_b), 0);
        chk("t5_async_c", int'(act_c), 0);
        repeat (2) tick();
        n_reset = 1'b1; mw = 1'b0;
        repeat (4) tick();
        chk("t5_idle_after_reset", int'(a_if.busy), 0);
        nc = 1'b1;
        tick();
        chk("t5_restart_load", int'(a_if.load_coeff), 1);
        chk("t5_restart_idx", int'(a_if.coefficient_num), 0);
        nc = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/param_coeff_loader.md
Name: param_coeff_loader

Overview:
Parametrised coefficient loader for the FIR filter datapath. It sequences loading of NUM_COEFF coefficients into the coefficient register file, one per handshake with the datapath controller (modwait). It adds an abort/restart capability, an error flag for a stalled datapath, and a busy indicator. It sits between the AHB-lite slave register block and the FIR controller.

Parameters:
NUM_COEFF, 4, number of coefficients loaded per set (2..16)
IDX_W, $clog2(NUM_COEFF), width of coefficient_num
TIMEOUT, 255, maximum cycles spent in a wait state before the error flag is raised (1..65535)

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous active-low reset
new_coefficient_set  input  1  level: a new coefficient set is pending in the slave registers
modwait  input  1  datapath busy; a load is accepted only when this is low
abort  input  1  pulse: abandon the current set and return to IDLE without clearing new_coefficient_set
load_coeff  output  1  one-cycle strobe: load the coefficient selected by coefficient_num
coefficient_num  output  IDX_W  index of the coefficient being loaded or awaited
clear_new_coeff  output  1  one-cycle strobe after the last coefficient completes
busy  output  1  high in every state except IDLE
load_err  output  1  sticky: a wait exceeded TIMEOUT; cleared by the next accepted new set or by reset

Behaviour:
- Reset (async, n_reset low): state IDLE; index=0; timer=0. All outputs are 0.
- States: IDLE, LOAD, WAIT, CLEAR, plus an index register of IDX_W bits and a timer of 16 bits.
- IDLE: if new_coefficient_set=1 and abort=0, go to LOAD, set index=0 and clear load_err.
- LOAD: load_coeff=1 for exactly one cycle. Next state is WAIT with timer=0.
- WAIT: load_coeff=0. When modwait=0:
  - if index==NUM_COEFF-1, go to CLEAR;
  - otherwise increment index and go to LOAD.
  - While modwait=1, the timer increments. When the timer reaches TIMEOUT, set load_err=1, go to IDLE and reset index=0. clear_new_coeff is not asserted on this path.
- CLEAR: clear_new_coeff=1 for one cycle, then go to IDLE.
- coefficient_num equals index in LOAD and WAIT, and is 0 in IDLE and CLEAR.
- The minimum set duration is 2*NUM_COEFF+1 cycles from leaving IDLE to returning to IDLE, given modwait=0 throughout.
- abort has priority over all other transitions:
  - In any non-IDLE state, the next state is IDLE with index=0. No load_coeff or clear_new_coeff is generated in that cycle.
  - In IDLE, abort blocks the start of a set.
- abort and modwait=0 in the same WAIT cycle: abort wins.
- new_coefficient_set is sampled only in IDLE. Deassertion mid-set is ignored and the set completes.
- new_coefficient_set still high after CLEAR: since the slave sees clear_new_coeff, a new set starts only if the level is still high one cycle after returning to IDLE. There is no special case for this.
- Index never wraps: the WAIT exit at NUM_COEFF-1 goes to CLEAR. For a non-power-of-2 NUM_COEFF, the index never exceeds NUM_COEFF-1.
- All outputs are registered-state decodes (Moore). There is no combinational path from inputs to outputs.

Decomposition:
- Package coeff_pkg:
  - typedef enum logic [1:0] state_t {IDLE, LOAD, WAIT, CLEAR};
  - localparam DEFAULT_NUM_COEFF = 4;
  - localparam TIMER_W = 16.
- One sub-module: wait_timer (a clearable, enabled up-counter with a terminal-match output set by TIMEOUT). It is instantiated once, cleared in LOAD and enabled in WAIT while modwait=1.

Test Plan:
- Default NUM_COEFF=4, modwait=0, new_coefficient_set pulsed high → load_coeff strobes with coefficient_num 0,1,2,3 on alternating cycles; clear_new_coeff for 1 cycle at cycle 9; busy high for 9 cycles.
- modwait held high 3 cycles after each load → each WAIT extends by 3 cycles; coefficient_num held steady; exactly 4 load strobes and 1 clear.
- abort asserted during WAIT for index 2 → IDLE next cycle; no clear_new_coeff. With new_coefficient_set still high, a restart follows with coefficient_num=0.
- TIMEOUT=10, modwait stuck high after the first load → load_err=1 after 10 wait cycles, return to IDLE, no clear. The next new set clears load_err.
- NUM_COEFF=5 (IDX_W=3) → indices 0..4 loaded, clear follows index 4, coefficient_num never shows 5–7.
- n_reset asserted mid-WAIT → all outputs 0 immediately (async); after release, the block sits in IDLE until new_coefficient_set is high.
